key_schedule_ctrl: RTL and testbench
====================================

// Module: key_schedule_ctrl
// PURPOSE
//  Sequential AES key-schedule controller. Accepts a cipher key and expands it one
//  32-bit word per clock through a single shared 4-byte S-box path. It stores all
//  4*(NR+1) words and serves one 128-bit round key per request to the cipher round
//  controller. Replaces the fully unrolled combinational expansion with a low-area,
//  multi-cycle schedule.
// PARAMETERS
//  NK  4   key length in 32-bit words (4/6/8 -> AES-128/192/256)
//  NR  10  number of rounds (10/12/14; must pair with NK)
// PORTS
//  i_clk     in   1        clock; all logic on rising edge
//  i_rst     in   1        synchronous, active-high reset
//  i_key     in   NK*32    cipher key, [0:NK*32-1], byte 0 = i_key[0:7] = w0 MSB
//  i_vld     in   1        key-load strobe; sampled only when o_busy=0
//  o_busy    out  1        expansion in progress; i_vld ignored while high
//  o_ready   out  1        full schedule valid; round keys may be requested
//  i_rk_req  in   1        round-key read request
//  i_rk_idx  in   4        round index 0..NR
//  o_rk      out  128      round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, [0:127]
//  o_rk_vld  out  1        one-cycle pulse: o_rk holds the requested key
//  o_rk_err  out  1        one-cycle pulse: request rejected
// BEHAVIOUR
//  Reset: state=IDLE; o_busy=0, o_ready=0, o_rk=0, o_rk_vld=0, o_rk_err=0,
//   word counter=0, rcon=8'h01. Word storage is not cleared.
//  FSM IDLE -> EXPAND -> READY. READY -> EXPAND on a new i_vld (rekey).
//  Load edge (i_vld=1 in IDLE or READY): w[0..NK-1] <= i_key, cnt <= NK, rcon <= 01,
//   o_ready <= 0, o_busy <= 1, state <= EXPAND.
//  EXPAND, one word per edge: t = w[cnt-1].
//   cnt%NK==0       : t = SubWord(RotWord(t)) ^ {rcon,24'h0}; then rcon <= xtime(rcon)
//                     (0x80 -> 0x1B).
//   NK>6, cnt%NK==4 : t = SubWord(t).
//   w[cnt] <= w[cnt-NK] ^ t; cnt <= cnt+1.
//   Only one SubWord instance (4 S-boxes) is allowed; the S-box is combinational,
//   so there is no extra pipeline stage.
//  Completion: the edge that writes w[4*(NR+1)-1] sets state=READY, o_busy=0,
//   o_ready=1. Latency = 4*(NR+1)-NK edges after the load edge
//   (40 / 46 / 52 for AES-128/192/256).
//  Read: i_rk_req sampled at an edge in READY with i_rk_idx<=NR -> at that edge
//   o_rk <= key[idx] and o_rk_vld <= 1 for one cycle. One request per cycle,
//   back-to-back allowed, latency 1.
//  Request with state!=READY, or with i_rk_idx>NR -> o_rk_err=1 for one cycle,
//   o_rk_vld=0, o_rk holds its last value.
//  Simultaneous i_vld and i_rk_req in READY: the load wins. The request errors
//   (o_rk_err), and o_ready falls at that edge.
//  i_vld while o_busy=1: ignored. The expansion continues with the original key.
//  i_rst at any time, including mid-EXPAND: immediate return to reset values.
//   A fresh i_vld is required before any further reads.
//  cnt width = clog2(4*(NR+1)); wraps never (bounded by the completion compare).
// TESTING
//  T1 NK=4: load key 2b7e151628aed2a6abf7158809cf4f3c -> o_ready high exactly
//     40 edges later. Read idx 1 -> a0fafe1788542cb123a339392a6c7605;
//     idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; idx 0 -> the key itself.
//  T2 NK=8,NR=14: key 000102..1f -> o_ready after 52 edges. Read idx 14 ->
//     24fc79ccbf0979e9371ac23c6d68de36.
//  T3 Reads idx 0..10 on 11 consecutive cycles -> 11 consecutive o_rk_vld pulses,
//     correct keys, no gaps. Then read idx 11 -> o_rk_err=1, o_rk unchanged.
//  T4 i_rk_req mid-EXPAND -> o_rk_err pulse. A second i_vld with a different key
//     mid-EXPAND -> ignored; the T1 keys still result.
//  T5 Assert i_rst at EXPAND cycle 20 -> all outputs 0 next edge. Reload key ->
//     full correct schedule after 40 edges.
//  T6 In READY, i_vld with an all-zero key together with i_rk_req -> o_rk_err,
//     o_ready=0. After 40 edges, idx 10 -> b4ef5bcb3e92e21123e951cf6f8f188e.

Source files
------------

// File: rtl/key_schedule_ctrl.sv
// Sequential AES key-schedule controller.
// Expands the cipher key one 32-bit word per clock through one shared
// 4-byte S-box path, stores every expanded word, and returns one 128-bit
// round key for each request.
module key_schedule_ctrl #(
    parameter int NK = 4,    // key length in 32-bit words (4/6/8)
    parameter int NR = 10    // round count (10/12/14)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [0:NK*32-1] i_key,
    input  logic             i_vld,
    output logic             o_busy,
    output logic             o_ready,
    input  logic             i_rk_req,
    input  logic [3:0]       i_rk_idx,
    output logic [0:127]     o_rk,
    output logic             o_rk_vld,
    output logic             o_rk_err
);

    localparam int TOTAL = 4 * (NR + 1);
    localparam int CW    = $clog2(TOTAL);

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    // GF(2^8) multiply by x, reduced by the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by
    // the affine transform; keeps the 256-entry table out of the source.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0]   w_mem [0:TOTAL-1];
    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    phase_reg;     // cnt mod NK, tracked incrementally
    logic [7:0]    rcon_reg;

    logic          load;
    logic          last_word;
    logic          rd_ok;
    logic [CW-1:0] rd_base;
    logic [31:0]   t_prev;
    logic [31:0]   sub_in;
    logic [31:0]   sub_out;
    logic [31:0]   t_word;

    // A load is accepted whenever no expansion is running
    assign load      = i_vld && (state_reg != EXPAND);
    assign last_word = (cnt_reg == CW'(TOTAL - 1));
    assign o_busy    = (state_reg == EXPAND);
    assign o_ready   = (state_reg == READY);

    // A simultaneous load pre-empts a read in READY
    assign rd_ok   = i_rk_req && (state_reg == READY) && !i_vld && (i_rk_idx <= 4'(NR));
    assign rd_base = CW'({i_rk_idx, 2'b00});

    // Single shared SubWord path; RotWord only on the rcon step
    assign t_prev = w_mem[cnt_reg - CW'(1)];
    assign sub_in = (phase_reg == 3'd0) ? {t_prev[23:0], t_prev[31:24]} : t_prev;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign sub_out[gi*8 +: 8] = sbox(sub_in[gi*8 +: 8]);
        end
    endgenerate

    // Select the transformed temp word for the current position in the key block
    always_comb begin
        t_word = t_prev;
        if (phase_reg == 3'd0) begin
            t_word = sub_out ^ {rcon_reg, 24'h000000};
        end else if ((NK > 6) && (phase_reg == 3'd4)) begin
            t_word = sub_out;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = EXPAND;
            EXPAND:  if (last_word) state_next = READY;
            READY:   if (load) state_next = EXPAND;
            default: state_next = IDLE;
        endcase
    end

    // Word counter, position-in-block and round constant
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_reg   <= '0;
            phase_reg <= 3'd0;
            rcon_reg  <= 8'h01;
        end else if (load) begin
            cnt_reg   <= CW'(NK);
            phase_reg <= 3'd0;
            rcon_reg  <= 8'h01;
        end else if (state_reg == EXPAND) begin
            cnt_reg   <= cnt_reg + CW'(1);
            phase_reg <= (phase_reg == 3'(NK - 1)) ? 3'd0 : phase_reg + 3'd1;
            if (phase_reg == 3'd0) rcon_reg <= xtime(rcon_reg);
        end
    end

    // Word storage: key words on load, one expanded word per EXPAND cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (load) begin
                for (int i = 0; i < NK; i++) w_mem[i] <= i_key[i*32 +: 32];
            end else if (state_reg == EXPAND) begin
                w_mem[cnt_reg] <= w_mem[cnt_reg - CW'(NK)] ^ t_word;
            end
        end
    end

    // Round-key read port with one-cycle valid/error pulses
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rk     <= '0;
            o_rk_vld <= 1'b0;
            o_rk_err <= 1'b0;
        end else begin
            o_rk_vld <= rd_ok;
            o_rk_err <= i_rk_req && !rd_ok;
            if (rd_ok) begin
                o_rk <= {w_mem[rd_base], w_mem[rd_base + CW'(1)],
                         w_mem[rd_base + CW'(2)], w_mem[rd_base + CW'(3)]};
            end
        end
    end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Self-checking bench for key_schedule_ctrl: AES-128 instance for most
// scenarios plus an AES-256 instance for the longer schedule.
module tb_key_schedule_ctrl;

    logic           clk = 1'b0;
    logic           rst;
    logic [0:127]   key;
    logic           vld, req;
    logic [3:0]     idx;
    logic           busy, ready, rk_vld, rk_err;
    logic [0:127]   rk;

    logic [0:255]   key8;
    logic           vld8, req8;
    logic [3:0]     idx8;
    logic           busy8, ready8, rk_vld8, rk_err8;
    logic [0:127]   rk8;

    always #5 clk = ~clk;

    key_schedule_ctrl #(.NK(4), .NR(10)) dut (
        .i_clk(clk), .i_rst(rst), .i_key(key), .i_vld(vld),
        .o_busy(busy), .o_ready(ready), .i_rk_req(req), .i_rk_idx(idx),
        .o_rk(rk), .o_rk_vld(rk_vld), .o_rk_err(rk_err)
    );

    key_schedule_ctrl #(.NK(8), .NR(14)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_key(key8), .i_vld(vld8),
        .o_busy(busy8), .o_ready(ready8), .i_rk_req(req8), .i_rk_idx(idx8),
        .o_rk(rk8), .o_rk_vld(rk_vld8), .o_rk_err(rk_err8)
    );

    typedef struct packed {
        logic         err;
        logic [127:0] key;
    } exp_t;

    exp_t         sb_q[$];
    logic [127:0] rk_tab [0:10];
    logic [127:0] last_rk;
    int           n_checks = 0;
    int           n_errors = 0;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request cycle: expectation pushed when driven, popped one edge later
    task automatic do_req(input string tag, input logic [3:0] i,
                          input logic exp_err, input logic [127:0] exp_key);
        exp_t e;
        sb_q.push_back({exp_err, exp_err ? last_rk : exp_key});
        req = 1'b1;
        idx = i;
        tick();
        req = 1'b0;
        e = sb_q.pop_front();
        chk({tag, "_vld"}, 128'(rk_vld), 128'(!e.err));
        chk({tag, "_err"}, 128'(rk_err), 128'(e.err));
        chk({tag, "_rk"}, rk, e.key);
        if (!e.err) last_rk = e.key;
        $display("req %s idx=%0d err=%0b rk=%h", tag, i, rk_err, rk);
    endtask

    // Counts edges until o_ready, starting from edges already elapsed since load
    task automatic wait_ready(input string tag, input int already, input int exp_n);
        int n;
        n = already;
        while (ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 128'(n), 128'(exp_n));
        $display("load %s ready after %0d edges", tag, n);
    endtask

    initial begin
        int n;
        rk_tab[0]  = K1;
        rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst = 1'b1; key = '0; vld = 1'b0; req = 1'b0; idx = 4'd0;
        key8 = '0; vld8 = 1'b0; req8 = 1'b0; idx8 = 4'd0;
        last_rk = '0;
        tick();
        tick();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_ready", 128'(ready), 128'(0));
        chk("rst_rk", rk, 128'(0));
        chk("rst_vld", 128'(rk_vld), 128'(0));
        chk("rst_err", 128'(rk_err), 128'(0));
        chk("rst_ready8", 128'(ready8), 128'(0));
        rst = 1'b0;

        // Request while idle is rejected
        do_req("idle", 4'd0, 1'b1, '0);

        // T1 + T4: load, request mid-expand, ignored second load
        key = K1; vld = 1'b1;
        tick();
        vld = 1'b0;
        chk("t1_busy", 128'(busy), 128'(1));
        chk("t1_notready", 128'(ready), 128'(0));
        repeat (5) tick();
        do_req("t4_mid", 4'd2, 1'b1, '0);
        key = 128'h0123456789abcdef0123456789abcdef; vld = 1'b1;
        tick();
        vld = 1'b0;
        key = K1;
        wait_ready("t1_lat", 7, 40);
        chk("t1_busy_done", 128'(busy), 128'(0));
        do_req("t1_idx1", 4'd1, 1'b0, rk_tab[1]);
        do_req("t1_idx10", 4'd10, 1'b0, rk_tab[10]);
        do_req("t1_idx0", 4'd0, 1'b0, rk_tab[0]);

        // T3: back-to-back reads, then out-of-range indices
        for (int i = 0; i <= 10; i++) do_req("t3_seq", 4'(i), 1'b0, rk_tab[i]);
        do_req("t3_idx11", 4'd11, 1'b1, '0);
        do_req("t3_idx15", 4'd15, 1'b1, '0);
        tick();
        chk("t3_quiet_vld", 128'(rk_vld), 128'(0));
        chk("t3_quiet_err", 128'(rk_err), 128'(0));

        // T2: AES-256 schedule on the second instance
        key8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        vld8 = 1'b1;
        tick();
        vld8 = 1'b0;
        n = 0;
        while (ready8 !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("t2_lat", 128'(n), 128'(52));
        $display("load t2 ready after %0d edges", n);
        req8 = 1'b1; idx8 = 4'd14;
        tick();
        req8 = 1'b0;
        chk("t2_vld", 128'(rk_vld8), 128'(1));
        chk("t2_idx14", rk8, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        $display("req t2 idx=14 rk=%h", rk8);

        // T5: reset in the middle of an expansion
        vld = 1'b1;
        tick();
        vld = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_rk = '0;
        chk("t5_busy", 128'(busy), 128'(0));
        chk("t5_ready", 128'(ready), 128'(0));
        chk("t5_rk", rk, 128'(0));
        chk("t5_vld", 128'(rk_vld), 128'(0));
        chk("t5_err", 128'(rk_err), 128'(0));
        tick();
        chk("t5_stay_idle", 128'(busy), 128'(0));
        do_req("t5_noreload", 4'd1, 1'b1, '0);
        vld = 1'b1;
        tick();
        vld = 1'b0;
        wait_ready("t5_lat", 0, 40);
        do_req("t5_idx10", 4'd10, 1'b0, rk_tab[10]);
        do_req("t5_idx4", 4'd4, 1'b0, rk_tab[4]);

        // T6: rekey with zero key collides with a request; load wins
        key = '0; vld = 1'b1;
        do_req("t6_collide", 4'd3, 1'b1, '0);
        vld = 1'b0;
        chk("t6_ready_fall", 128'(ready), 128'(0));
        chk("t6_busy", 128'(busy), 128'(1));
        wait_ready("t6_lat", 0, 40);
        do_req("t6_idx10", 4'd10, 1'b0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        do_req("t6_idx0", 4'd0, 1'b0, 128'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
